// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-net pattern sequencer.
package nn_pkg;

    localparam int          DEF_BITS = 16;
    localparam int          DEF_NX   = 6;
    localparam logic [15:0] LR_FLOOR = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_TRAIN,
        ST_VALID,
        ST_EPOCH_END,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/miss_counter.sv
// Working miss counter for one validation pass, with a snapshot register
// holding the result of the last completed pass.
module miss_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    input  logic         snapshot,
    output logic [W-1:0] err_count
);

    logic [W-1:0] work_q, work_d;
    logic [W-1:0] snap_q, snap_d;

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        work_d = work_q;
        snap_d = snap_q;
        if (clear) begin
            work_d = '0;
        end else if (snapshot) begin
            snap_d = work_q;
            work_d = '0;
        end else if (inc) begin
            work_d = work_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            snap_q <= '0;
        end else begin
            work_q <= work_d;
            snap_q <= snap_d;
        end
    end

    assign err_count = snap_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Epoch/pattern sequencer feeding training and validation patterns to the network.
// Optional macro LR_DECAY_EN halves lr (floored at 1) at the end of every epoch.
module pattern_sequencer
    import nn_pkg::*;
#(
    parameter int             NX      = DEF_NX,
    parameter int             BITS    = DEF_BITS,
    parameter int             N_TRAIN = 200,
    parameter int             N_VAL   = 50,
    parameter int             EPOCHS  = 10,
    parameter logic [BITS-1:0] LR_INIT = 16'h0010,
    parameter int             ADDR_W  = $clog2(N_TRAIN + N_VAL),
    parameter int             EPOCH_W = $clog2(EPOCHS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [NX*BITS-1:0]   mem_x,
    input  logic [BITS-1:0]      mem_y,
    output logic [NX*BITS-1:0]   x,
    output logic [BITS-1:0]      y,
    output logic [BITS-1:0]      lr,
    output logic                 TR,
    output logic                 VL,
    output logic                 END,
    input  logic                 S_Train,
    input  logic                 S_Error,
    input  logic [BITS-1:0]      Error,
    output logic [ADDR_W-1:0]    err_count,
    output logic [EPOCH_W-1:0]   epoch,
    output logic                 busy
);

    seq_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic [BITS-1:0]      lr_q, lr_d;
    logic [NX*BITS-1:0]   x_q, x_d;
    logic [BITS-1:0]      y_q, y_d;
    logic                 clear_miss, inc_miss, snap_miss;

    logic in_train, last_train, last_val, last_epoch;

    assign in_train   = int'(addr_q) < N_TRAIN;
    assign last_train = int'(addr_q) == N_TRAIN - 1;
    assign last_val   = int'(addr_q) == N_TRAIN + N_VAL - 1;
    assign last_epoch = int'(epoch_q) == EPOCHS - 1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        epoch_d    = epoch_q;
        lr_d       = lr_q;
        x_d        = x_q;
        y_d        = y_q;
        clear_miss = 1'b0;
        inc_miss   = 1'b0;
        snap_miss  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = '0;
                    epoch_d    = '0;
                    lr_d       = LR_INIT;
                    clear_miss = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                x_d     = mem_x;
                y_d     = mem_y;
                state_d = in_train ? ST_TRAIN : ST_VALID;
            end
            ST_TRAIN: begin
                if (S_Train) begin
                    // With no validation set the epoch ends straight after training.
                    if (last_train && N_VAL == 0) begin
                        state_d = ST_EPOCH_END;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_VALID: begin
                if (S_Error) begin
                    inc_miss = (Error != '0);
                    if (last_val) begin
                        state_d = ST_EPOCH_END;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_EPOCH_END: begin
                snap_miss = 1'b1;
`ifdef LR_DECAY_EN
                lr_d = ((lr_q >> 1) == '0) ? BITS'(LR_FLOOR) : (lr_q >> 1);
`endif
                if (last_epoch) begin
                    state_d = ST_DONE;
                end else begin
                    epoch_d = epoch_q + EPOCH_W'(1);
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            epoch_q <= '0;
            lr_q    <= LR_INIT;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            epoch_q <= epoch_d;
            lr_q    <= lr_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    miss_counter #(.W(ADDR_W)) u_miss_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_miss),
        .inc       (inc_miss),
        .snapshot  (snap_miss),
        .err_count (err_count)
    );

    assign mem_rd   = (state_q == ST_FETCH);
    assign mem_addr = addr_q;
    assign x        = x_q;
    assign y        = y_q;
    assign lr       = lr_q;
    assign TR       = (state_q == ST_TRAIN);
    assign VL       = (state_q == ST_VALID);
    assign END      = (state_q == ST_DONE);
    assign epoch    = epoch_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Upstream pattern and control stage for the neural-net Architecture block.
- Walks a pattern memory for EPOCHS epochs. Each epoch runs N_TRAIN training patterns (TR handshake), then N_VAL validation patterns (VL handshake).
- Drives x/y/lr to the network and counts validation misclassifications per epoch.
- Raises END when all epochs are done.

Parameters:
- NX, 6, input features per pattern
- BITS, 16, fixed-point word width (x, y, lr, Error)
- N_TRAIN, 200, training patterns per epoch (addresses 0..N_TRAIN-1)
- N_VAL, 50, validation patterns per epoch (addresses N_TRAIN..N_TRAIN+N_VAL-1)
- EPOCHS, 10, number of epochs (>=1)
- LR_INIT, 16'h0010, learning rate loaded at start
- ADDR_W, $clog2(N_TRAIN+N_VAL), pattern memory address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse in IDLE begins a run; ignored elsewhere
- mem_rd  out  1  pattern memory read strobe
- mem_addr  out  ADDR_W  pattern memory address
- mem_x  in  NX*BITS  pattern features; valid exactly 1 cycle after mem_rd
- mem_y  in  BITS  pattern label; valid with mem_x
- x  out  NX*BITS  registered features to network
- y  out  BITS  registered label to network
- lr  out  BITS  learning rate to network
- TR  out  1  training request
- VL  out  1  validation request
- END  out  1  run complete
- S_Train  in  1  training pattern complete (from network)
- S_Error  in  1  validation pattern complete (from network)
- Error  in  BITS  0 = correct, nonzero = miss; sampled with S_Error
- err_count  out  ADDR_W  misses in the last completed validation pass
- epoch  out  $clog2(EPOCHS+1)  current epoch index, 0-based
- busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset: all outputs 0 except lr = LR_INIT; FSM goes to IDLE. Reset mid-run aborts immediately; no partial state survives.
- States: IDLE, FETCH, LOAD, TRAIN, VALID, EPOCH_END, DONE.
- IDLE: on start, set addr=0, epoch=0, lr=LR_INIT, clear the working miss counter, go to FETCH.
- FETCH: mem_rd=1 for one cycle with mem_addr=addr; go to LOAD.
- LOAD: capture mem_x/mem_y into x/y. Go to TRAIN if addr<N_TRAIN, else VALID.
- TRAIN: TR=1, x/y held stable. On the cycle S_Train is sampled 1, TR drops next cycle and addr increments. Next state is FETCH, or FETCH of address N_TRAIN at the phase boundary.
- VALID: VL=1, x/y held stable. On the cycle S_Error is sampled 1, the working counter increments if Error!=0 and VL drops next cycle. Next state is FETCH, or EPOCH_END after the last pattern (addr==N_TRAIN+N_VAL-1).
- EPOCH_END: one cycle. err_count <= working counter; working counter cleared. If epoch==EPOCHS-1 go to DONE, else epoch++, addr=0, go to FETCH.
- DONE: END=1 held until reset; start is ignored.
- Request gap: TR/VL is low for at least 2 cycles (FETCH, LOAD) between consecutive patterns.
- Minimum latency from S_Train/S_Error to the next TR/VL rise is 3 cycles.
- TR and VL are never high together.
- Spurious S_Train outside TRAIN, or spurious S_Error outside VALID, is ignored.
- S_Train and S_Error high together: only the one matching the current state is honoured.
- Error arriving the same cycle as S_Error is counted; Error without S_Error is ignored.
- Counter width ADDR_W cannot overflow (bounded by N_VAL).
- N_VAL=0: go from the last TRAIN pattern straight to EPOCH_END; err_count=0.

Optional Feature:
- Macro: LR_DECAY_EN.
- Defined: in EPOCH_END, lr <= lr>>1 (logical), floored at 16'h0001; lr is never 0.
- Undefined: lr stays LR_INIT for the whole run.

Decomposition:
- Shared package nn_pkg: seq_state_e enum; BITS and NX defaults; LR_FLOOR constant (16'h0001).
- One sub-module, miss_counter: clear/increment/snapshot logic driving err_count.

Test Plan:
- N_TRAIN=3, N_VAL=2, EPOCHS=1; network model pulses S_Train 5 cycles after each TR rise -> TR rises 3 times with x matching mem[0..2], then VL twice with mem[3..4], END=1 and busy=0.
- Validation Error sequence 0,5 -> err_count=1 after EPOCH_END; next epoch Error 1,1 -> err_count=2; epoch reads 0 then 1.
- S_Error pulsed during TRAIN and S_Train pulsed during VALID -> no address advance, no count change, TR/VL unchanged.
- Assert rst_n low during the second TRAIN pattern -> TR=0, END=0, err_count=0, state IDLE; new start replays from address 0.
- With LR_DECAY_EN, LR_INIT=16'h0004, EPOCHS=4 -> lr per epoch 4, 2, 1, 1. Without the macro -> lr 4 every epoch.
- Back-to-back S_Train held high for 2 cycles -> only one address advance; TR low for exactly 2 cycles before the next rise.
